wb_stage: RTL and testbench

- MEM/WB pipeline register plus writeback-side logic for the pipelined MIPS core.
- Latches MEM-stage results and applies load sub-word extraction and sign/zero extension.
- Selects ALU result, load data or link address (PC+4).
- Drives WriteData/WriteRegister/RegWrite, which the register file write port and the read-side bypass logic consume. Also keeps a retired-instruction counter.

---
 rtl/wb_stage.sv | 74 +++++++
 tb/tb_wb_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB register with load extend, writeback mux (WriteData/WriteRegister/RegWrite) and retire counter
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W = 5,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic              mem_mem_to_reg,
  input  logic              mem_link,
  input  logic [1:0]        mem_ld_size,
  input  logic              mem_ld_unsigned,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic [DATA_W-1:0] mem_pc_plus4,
  input  logic [REG_W-1:0]  mem_write_reg,
  output logic [DATA_W-1:0] WriteData,
  output logic [REG_W-1:0]  WriteRegister,
  output logic              RegWrite,
  output logic              wb_valid,
  output logic [31:0]       retired_count
);
  logic v, rw, m2r, lk, uns;
  logic [1:0] sz;
  logic [DATA_W-1:0] alu, rd, pc4, ld;
  logic [REG_W-1:0] wr;
  logic [7:0] b;
  logic [15:0] h;
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      v   <= 1'b0;
      rw  <= 1'b0;
      m2r <= 1'b0;
      lk  <= 1'b0;
      uns <= 1'b0;
      sz  <= '0;
      alu <= '0;
      rd  <= '0;
      pc4 <= '0;
      wr  <= '0;
    end else if (!stall) begin
      v   <= mem_valid;
      rw  <= mem_reg_write;
      m2r <= mem_mem_to_reg;
      lk  <= mem_link;
      uns <= mem_ld_unsigned;
      sz  <= mem_ld_size;
      alu <= mem_alu_result;
      rd  <= mem_read_data;
      pc4 <= mem_pc_plus4;
      wr  <= mem_write_reg;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n)
      retired_count <= '0;
    else if (v && !stall)
      retired_count <= retired_count + 32'd1;
  end
  always_comb begin
    b = rd[{alu[1:0], 3'b000} +: 8];
    h = alu[1] ? rd[31:16] : rd[15:0];
    ld = sz == 2'b00 ? {{(DATA_W-8){b[7] & ~uns}}, b} :
         sz == 2'b01 ? {{(DATA_W-16){h[15] & ~uns}}, h} : rd;
    WriteRegister = lk ? REG_W'(LINK_REG) : wr;
    WriteData = lk ? pc4 : m2r ? ld : alu;
    RegWrite = v & rw & ~stall & (WriteRegister != '0);
    wb_valid = v;
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: table vectors, directed stall/flush/reset sequences and randomized model check for wb_stage
module tb_wb_stage;
  logic clk = 1'b0;
  logic rst_n, stall, flush, mem_valid, mem_reg_write, mem_mem_to_reg, mem_link, mem_ld_unsigned;
  logic [1:0] mem_ld_size;
  logic [31:0] mem_alu_result, mem_read_data, mem_pc_plus4;
  logic [4:0] mem_write_reg;
  logic [31:0] WriteData;
  logic [4:0] WriteRegister;
  logic RegWrite, wb_valid;
  logic [31:0] retired_count;
  int checks = 0;
  int errors = 0;

  wb_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
    .mem_link(mem_link), .mem_ld_size(mem_ld_size), .mem_ld_unsigned(mem_ld_unsigned),
    .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data), .mem_pc_plus4(mem_pc_plus4),
    .mem_write_reg(mem_write_reg), .WriteData(WriteData), .WriteRegister(WriteRegister),
    .RegWrite(RegWrite), .wb_valid(wb_valid), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v, rw, m2r, lk, uns;
    bit [1:0] sz;
    bit [31:0] alu, rd, pc4;
    bit [4:0] wr;
  } wbrec_t;

  typedef struct {
    logic [31:0] alu, rd, pc4;
    logic [4:0] wr;
    logic [1:0] sz;
    logic uns, lk, m2r, rw;
    logic [31:0] ed;
    logic [4:0] er;
    logic ew;
  } vec_t;

  wbrec_t m;
  bit zb;
  bit [31:0] cnt;
  vec_t tv[8];

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  function automatic bit [31:0] exp_load();
    bit [31:0] x;
    if (m.sz == 2'd0) begin
      x = (m.rd >> (8 * int'(m.alu[1:0]))) & 32'hFF;
      if (!m.uns && x >= 32'h80) x = x + 32'hFFFF_FF00;
    end else if (m.sz == 2'd1) begin
      x = (m.rd >> (16 * int'(m.alu[1]))) & 32'hFFFF;
      if (!m.uns && x >= 32'h8000) x = x + 32'hFFFF_0000;
    end else x = m.rd;
    return x;
  endfunction

  function automatic bit [31:0] exp_data();
    return m.lk ? m.pc4 : m.m2r ? exp_load() : m.alu;
  endfunction

  function automatic bit [4:0] exp_reg();
    return m.lk ? 5'd31 : m.wr;
  endfunction

  function automatic bit exp_rw();
    return m.v && m.rw && !stall && exp_reg() != 5'd0;
  endfunction

  task automatic tick();
    cnt = !rst_n ? 32'd0 : (m.v && !stall) ? cnt + 32'd1 : cnt;
    if (!rst_n || flush) begin
      m = '{default: 0};
      zb = 1'b1;
    end else if (!stall) begin
      m.v = mem_valid; m.rw = mem_reg_write; m.m2r = mem_mem_to_reg; m.lk = mem_link;
      m.uns = mem_ld_unsigned; m.sz = mem_ld_size; m.alu = mem_alu_result;
      m.rd = mem_read_data; m.pc4 = mem_pc_plus4; m.wr = mem_write_reg;
      zb = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("wb_valid", 32'(wb_valid), 32'(m.v));
    chk("retired_count", retired_count, cnt);
    chk("RegWrite", 32'(RegWrite), 32'(exp_rw()));
    if (m.v || zb) begin
      chk("WriteData", WriteData, exp_data());
      chk("WriteRegister", 32'(WriteRegister), 32'(exp_reg()));
    end
  endtask

  task automatic set_in(bit v, bit rw, bit m2r, bit lk, bit [1:0] sz, bit uns,
                        bit [31:0] alu, bit [31:0] rd, bit [31:0] pc4, bit [4:0] wr);
    mem_valid = v; mem_reg_write = rw; mem_mem_to_reg = m2r; mem_link = lk;
    mem_ld_size = sz; mem_ld_unsigned = uns; mem_alu_result = alu;
    mem_read_data = rd; mem_pc_plus4 = pc4; mem_write_reg = wr;
  endtask

  task automatic rand_in();
    set_in(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
           2'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 5'($urandom));
  endtask

  initial begin
    tv[0] = '{32'h0000_1234, 32'h0, 32'h0, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 5'd8, 1'b1};
    tv[1] = '{32'h0000_1003, 32'h80FF_7F01, 32'h0, 5'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FF80, 5'd3, 1'b1};
    tv[2] = '{32'h0000_2001, 32'h80FF_7F01, 32'h0, 5'd4, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_007F, 5'd4, 1'b1};
    tv[3] = '{32'h0000_3002, 32'h80FF_7F01, 32'h0, 5'd5, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_80FF, 5'd5, 1'b1};
    tv[4] = '{32'h0000_4000, 32'h80FF_7F01, 32'h0, 5'd6, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_7F01, 5'd6, 1'b1};
    tv[5] = '{32'h0000_5000, 32'h80FF_7F01, 32'h0, 5'd7, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80FF_7F01, 5'd7, 1'b1};
    tv[6] = '{32'h0000_DEAD, 32'h0, 32'h0040_0010, 5'd0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0040_0010, 5'd31, 1'b1};
    tv[7] = '{32'h0000_0077, 32'h0, 32'h0, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0077, 5'd0, 1'b0};
    m = '{default: 0};
    zb = 1'b1;
    cnt = 0;
    rst_n = 1'b0; stall = 1'b1; flush = 1'b1;
    rand_in();
    tick();
    tick();
    chk("reset_data", WriteData, 32'h0);
    chk("reset_count", retired_count, 32'h0);
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, tv[i].rw, tv[i].m2r, tv[i].lk, tv[i].sz, tv[i].uns, tv[i].alu, tv[i].rd, tv[i].pc4, tv[i].wr);
      tick();
      chk("tv_data", WriteData, tv[i].ed);
      chk("tv_reg", 32'(WriteRegister), 32'(tv[i].er));
      chk("tv_regwrite", 32'(RegWrite), 32'(tv[i].ew));
      chk("tv_count", retired_count, 32'(i));
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    chk("count_after_table", retired_count, 32'd8);
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_ABCD, 32'h0, 32'h0, 5'd9);
    tick();
    chk("pre_stall_rw", 32'(RegWrite), 32'd1);
    stall = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_1111, 32'h0, 32'h0, 5'd10);
    #1;
    chk("stall_rw_comb", 32'(RegWrite), 32'd0);
    repeat (3) tick();
    chk("stall_hold_data", WriteData, 32'h0000_ABCD);
    chk("stall_hold_reg", 32'(WriteRegister), 32'd9);
    chk("stall_count", retired_count, 32'd8);
    stall = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    #1;
    chk("release_rw", 32'(RegWrite), 32'd1);
    tick();
    chk("release_count", retired_count, 32'd9);
    chk("release_rw_after", 32'(RegWrite), 32'd0);
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0BAD, 32'h0, 32'h0, 5'd11);
    tick();
    stall = 1'b1; flush = 1'b1;
    tick();
    chk("flush_valid", 32'(wb_valid), 32'd0);
    chk("flush_rw", 32'(RegWrite), 32'd0);
    chk("flush_data", WriteData, 32'h0);
    stall = 1'b0; flush = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    chk("flush_count", retired_count, 32'd9);
    for (int i = 0; i < 400; i++) begin
      rand_in();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 49) != 0);
      tick();
    end
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_in();
      mem_valid = 1'b1;
      tick();
    end
    chk("midstream_count", retired_count, 32'd5);
    rst_n = 1'b0;
    tick();
    chk("rst_valid", 32'(wb_valid), 32'd0);
    chk("rst_rw", 32'(RegWrite), 32'd0);
    chk("rst_reg", 32'(WriteRegister), 32'd0);
    chk("rst_data", WriteData, 32'd0);
    chk("rst_count", retired_count, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
